// File: rtl/tx_sched.sv
// Transmit scheduler: scans NUM_MB mailboxes for the best CAN priority key,
// raises the LLC transmission request and tracks done/abort per mailbox.
module tx_sched #(
    parameter int NUM_MB = 4,
    parameter int IDX_W  = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 initreqr,
    input  logic [NUM_MB-1:0]    txreq,
    input  logic [NUM_MB-1:0]    txabort,
    input  logic [NUM_MB*29-1:0] mbid,
    input  logic [NUM_MB-1:0]    mbext,
    input  logic                 trans,
    input  logic                 sucftranc,
    input  logic                 arblost,
    output logic                 traregbit,
    output logic [IDX_W-1:0]     selmb,
    output logic [NUM_MB-1:0]    pending,
    output logic [NUM_MB-1:0]    txdone,
    output logic [NUM_MB-1:0]    txabrtd,
    output logic [1:0]           sched_state
);

    // Handshake: txreq/txabort are single-cycle pulses with no back-pressure;
    // traregbit stays high until the LLC raises trans, which hands the frame
    // to the MAC; sucftranc/arblost close the frame and are only honoured in TX.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        REQ  = 2'd2,
        TX   = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [IDX_W-1:0]   best, best_n;
    logic               bestvalid, bestvalid_n;
    logic [29:0]        bestkey, bestkey_n;
    logic               abortflag, abortflag_n;
    logic               trareg_n;
    logic [IDX_W-1:0]   selmb_n;
    logic [NUM_MB-1:0]  pending_n, done_n, abrtd_n;
    logic [NUM_MB-1:0]  clr, abort_acc, sel_oh;
    logic [29:0]        key [NUM_MB];
    logic               take, cand_valid;
    logic [IDX_W-1:0]   cand_idx;
    logic [29:0]        cand_key;

    // Standard frames zero the extended bits, so they beat extended frames
    // sharing the same base ID.
    always_comb begin
        for (int k = 0; k < NUM_MB; k++) begin
            key[k] = {mbid[29*k+18 +: 11], mbext[k],
                      mbext[k] ? mbid[29*k +: 18] : 18'b0};
        end
    end

    always_comb begin
        sel_oh        = '0;
        sel_oh[selmb] = 1'b1;
    end

    // Strict less-than keeps the lower index on equal keys.
    always_comb begin
        take       = pending[idx] && (!bestvalid || (key[idx] < bestkey));
        cand_valid = take || bestvalid;
        cand_idx   = take ? idx : best;
        cand_key   = take ? key[idx] : bestkey;
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        best_n      = best;
        bestvalid_n = bestvalid;
        bestkey_n   = bestkey;
        abortflag_n = abortflag;
        trareg_n    = traregbit;
        selmb_n     = selmb;
        done_n      = '0;
        abrtd_n     = '0;
        clr         = '0;
        abort_acc   = txabort & ~(((state == REQ) || (state == TX)) ? sel_oh : '0);

        case (state)
            IDLE: begin
                trareg_n = 1'b0;
                if (pending != '0) begin
                    state_n     = ARB;
                    idx_n       = '0;
                    bestvalid_n = 1'b0;
                end
            end
            ARB: begin
                best_n      = cand_idx;
                bestvalid_n = cand_valid;
                bestkey_n   = cand_key;
                if (idx == IDX_W'(NUM_MB - 1)) begin
                    // A winner aborted mid-scan is dropped; IDLE re-arbitrates.
                    if (cand_valid && pending[cand_idx] && !txabort[cand_idx]) begin
                        selmb_n  = cand_idx;
                        trareg_n = 1'b1;
                        state_n  = REQ;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            REQ: begin
                if (trans) begin
                    state_n  = TX;
                    trareg_n = 1'b0;
                    if (txabort[selmb]) abortflag_n = 1'b1;
                end else if (txabort[selmb]) begin
                    clr      = sel_oh;
                    abrtd_n  = sel_oh;
                    trareg_n = 1'b0;
                    state_n  = IDLE;
                end
            end
            TX: begin
                trareg_n = 1'b0;
                if (txabort[selmb]) abortflag_n = 1'b1;
                if (sucftranc) begin
                    done_n      = sel_oh;
                    clr         = sel_oh;
                    abortflag_n = 1'b0;
                    state_n     = IDLE;
                end else if (arblost) begin
                    if (abortflag || txabort[selmb]) begin
                        abrtd_n = sel_oh;
                        clr     = sel_oh;
                    end
                    abortflag_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        abrtd_n   = abrtd_n | abort_acc;
        clr       = clr | abort_acc;
        pending_n = (pending & ~clr) | (txreq & ~txabort);
    end

    always_ff @(posedge clock) begin
        if (reset || initreqr) begin
            state     <= IDLE;
            idx       <= '0;
            best      <= '0;
            bestvalid <= 1'b0;
            bestkey   <= '0;
            abortflag <= 1'b0;
            traregbit <= 1'b0;
            selmb     <= '0;
            pending   <= '0;
            txdone    <= '0;
            txabrtd   <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            best      <= best_n;
            bestvalid <= bestvalid_n;
            bestkey   <= bestkey_n;
            abortflag <= abortflag_n;
            traregbit <= trareg_n;
            selmb     <= selmb_n;
            pending   <= pending_n;
            txdone    <= done_n;
            txabrtd   <= abrtd_n;
        end
    end

    assign sched_state = state;

endmodule

// File: tb/tb_tx_sched.sv
// Directed bench for tx_sched: latency, priority order, retry, aborts,
// equal-key tie break and init clear mid-frame.
module tb_tx_sched;

    localparam int NUM_MB = 4;
    localparam int IDX_W  = 2;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd2;
    localparam logic [1:0] S_TX   = 2'd3;

    logic                 clock = 1'b0;
    logic                 reset, initreqr;
    logic [NUM_MB-1:0]    txreq, txabort, mbext;
    logic [NUM_MB*29-1:0] mbid;
    logic                 trans, sucftranc, arblost;
    logic                 traregbit;
    logic [IDX_W-1:0]     selmb;
    logic [NUM_MB-1:0]    pending, txdone, txabrtd;
    logic [1:0]           sched_state;

    int errors = 0;
    int checks = 0;

    tx_sched #(.NUM_MB(NUM_MB), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset(reset), .initreqr(initreqr),
        .txreq(txreq), .txabort(txabort), .mbid(mbid), .mbext(mbext),
        .trans(trans), .sucftranc(sucftranc), .arblost(arblost),
        .traregbit(traregbit), .selmb(selmb), .pending(pending),
        .txdone(txdone), .txabrtd(txabrtd), .sched_state(sched_state)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_mb(input int k, input logic [28:0] id, input logic ext);
        mbid[29*k +: 29] = id;
        mbext[k]         = ext;
    endtask

    // One-cycle txreq pulse; returns with the pulse consumed (1 edge).
    task automatic pulse_req(input logic [NUM_MB-1:0] m);
        txreq = m;
        step();
        txreq = '0;
    endtask

    // Counts edges (starting at 1 for the request edge) until traregbit.
    task automatic wait_req(output int cyc);
        cyc = 1;
        while (!traregbit && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic do_trans();
        trans = 1'b1;
        step();
        trans = 1'b0;
    endtask

    task automatic do_succ();
        sucftranc = 1'b1;
        step();
        sucftranc = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({traregbit, selmb, pending, txdone, txabrtd, sched_state} !== '0) begin
            errors++;
            $display("FAIL reset: trareg=%b selmb=%0d pend=%b done=%b abrtd=%b st=%0d, want all 0",
                     traregbit, selmb, pending, txdone, txabrtd, sched_state);
        end
    endtask

    task automatic test_single();
        int cyc;
        set_mb(2, 29'h123, 1'b0);
        pulse_req(4'b0100);
        wait_req(cyc);
        checks++;
        if (cyc !== 6 || traregbit !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: cyc=%0d trareg=%b, want 6/1", cyc, traregbit);
        end
        checks++;
        if (selmb !== 2'd2) begin
            errors++;
            $display("FAIL single_selmb: got %0d want 2", selmb);
        end
        do_trans();
        checks++;
        if (sched_state !== S_TX || traregbit !== 1'b0) begin
            errors++;
            $display("FAIL single_tx: st=%0d trareg=%b, want 3/0", sched_state, traregbit);
        end
        do_succ();
        checks++;
        if (txdone !== 4'b0100 || pending !== 4'b0000 || sched_state !== S_IDLE) begin
            errors++;
            $display("FAIL single_done: done=%b pend=%b st=%0d, want 0100/0000/0",
                     txdone, pending, sched_state);
        end
        step();
        checks++;
        if (txdone !== 4'b0000) begin
            errors++;
            $display("FAIL single_done_pulse: done=%b want 0000", txdone);
        end
    endtask

    task automatic test_priority();
        int cyc;
        logic [IDX_W-1:0] order [3];
        order[0] = 2'd3;
        order[1] = 2'd0;
        order[2] = 2'd1;
        set_mb(0, 29'h0246_0000, 1'b1);
        set_mb(3, 29'h0246_0000, 1'b0);
        set_mb(1, 29'h1FFC_0000, 1'b0);
        pulse_req(4'b1011);
        for (int i = 0; i < 3; i++) begin
            wait_req(cyc);
            checks++;
            if (traregbit !== 1'b1 || selmb !== order[i]) begin
                errors++;
                $display("FAIL priority_sel%0d: trareg=%b selmb=%0d want 1/%0d",
                         i, traregbit, selmb, order[i]);
            end
            do_trans();
            do_succ();
            checks++;
            if (txdone !== (4'b0001 << order[i])) begin
                errors++;
                $display("FAIL priority_done%0d: done=%b want mb%0d", i, txdone, order[i]);
            end
        end
        step();
        checks++;
        if (pending !== 4'b0000 || sched_state !== S_IDLE) begin
            errors++;
            $display("FAIL priority_end: pend=%b st=%0d want 0000/0", pending, sched_state);
        end
    endtask

    task automatic test_retry();
        int cyc;
        set_mb(1, 29'h0ABC_DEF0, 1'b1);
        pulse_req(4'b0010);
        wait_req(cyc);
        do_trans();
        arblost = 1'b1;
        step();
        arblost = 1'b0;
        checks++;
        if (pending !== 4'b0010 || txdone !== 4'b0000 || txabrtd !== 4'b0000 || sched_state !== S_IDLE) begin
            errors++;
            $display("FAIL retry_lost: pend=%b done=%b abrtd=%b st=%0d want 0010/0000/0000/0",
                     pending, txdone, txabrtd, sched_state);
        end
        wait_req(cyc);
        checks++;
        if (traregbit !== 1'b1 || selmb !== 2'd1 || cyc !== 6) begin
            errors++;
            $display("FAIL retry_rearb: trareg=%b selmb=%0d cyc=%0d want 1/1/6", traregbit, selmb, cyc);
        end
        do_trans();
        do_succ();
        checks++;
        if (txdone !== 4'b0010 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL retry_done: done=%b pend=%b want 0010/0000", txdone, pending);
        end
        step();
        checks++;
        if (txdone !== 4'b0000) begin
            errors++;
            $display("FAIL retry_once: done=%b want 0000", txdone);
        end
    endtask

    task automatic test_abort();
        int cyc;
        // abort while requesting
        pulse_req(4'b0010);
        wait_req(cyc);
        txabort = 4'b0010;
        step();
        txabort = '0;
        checks++;
        if (txabrtd !== 4'b0010 || traregbit !== 1'b0 || pending !== 4'b0000 || sched_state !== S_IDLE) begin
            errors++;
            $display("FAIL abort_req: abrtd=%b trareg=%b pend=%b st=%0d want 0010/0/0000/0",
                     txabrtd, traregbit, pending, sched_state);
        end
        // abort in TX completes on arbitration loss
        pulse_req(4'b0010);
        wait_req(cyc);
        do_trans();
        txabort = 4'b0010;
        step();
        txabort = '0;
        checks++;
        if (txabrtd !== 4'b0000 || pending !== 4'b0010 || sched_state !== S_TX) begin
            errors++;
            $display("FAIL abort_tx_hold: abrtd=%b pend=%b st=%0d want 0000/0010/3",
                     txabrtd, pending, sched_state);
        end
        arblost = 1'b1;
        step();
        arblost = 1'b0;
        checks++;
        if (txabrtd !== 4'b0010 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL abort_tx_lost: abrtd=%b pend=%b want 0010/0000", txabrtd, pending);
        end
        // abort in TX overtaken by success
        pulse_req(4'b0010);
        wait_req(cyc);
        do_trans();
        txabort = 4'b0010;
        step();
        txabort = '0;
        do_succ();
        checks++;
        if (txdone !== 4'b0010 || txabrtd !== 4'b0000 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL abort_tx_succ: done=%b abrtd=%b pend=%b want 0010/0000/0000",
                     txdone, txabrtd, pending);
        end
        step();
        checks++;
        if (txabrtd !== 4'b0000 || txdone !== 4'b0000) begin
            errors++;
            $display("FAIL abort_tx_succ_after: done=%b abrtd=%b want 0000/0000", txdone, txabrtd);
        end
    endtask

    task automatic test_nonsel_abort();
        int cyc;
        set_mb(0, 29'h0010_0000, 1'b0);
        set_mb(1, 29'h1FFC_0000, 1'b0);
        pulse_req(4'b0011);
        wait_req(cyc);
        txabort = 4'b0010;
        step();
        txabort = '0;
        checks++;
        if (txabrtd !== 4'b0010 || pending !== 4'b0001 || traregbit !== 1'b1 || sched_state !== S_REQ) begin
            errors++;
            $display("FAIL nonsel_abort: abrtd=%b pend=%b trareg=%b st=%0d want 0010/0001/1/2",
                     txabrtd, pending, traregbit, sched_state);
        end
        do_trans();
        do_succ();
        checks++;
        if (txdone !== 4'b0001 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL nonsel_done: done=%b pend=%b want 0001/0000", txdone, pending);
        end
    endtask

    task automatic test_equal_keys();
        int cyc;
        set_mb(0, 29'h0550_0000, 1'b0);
        set_mb(2, 29'h0550_0000, 1'b0);
        pulse_req(4'b0101);
        wait_req(cyc);
        checks++;
        if (selmb !== 2'd0) begin
            errors++;
            $display("FAIL equal_first: selmb=%0d want 0", selmb);
        end
        do_trans();
        do_succ();
        wait_req(cyc);
        checks++;
        if (selmb !== 2'd2 || traregbit !== 1'b1) begin
            errors++;
            $display("FAIL equal_second: selmb=%0d trareg=%b want 2/1", selmb, traregbit);
        end
        do_trans();
        do_succ();
        txreq   = 4'b1000;
        txabort = 4'b1000;
        step();
        txreq   = '0;
        txabort = '0;
        checks++;
        if (pending !== 4'b0000 || txabrtd !== 4'b1000) begin
            errors++;
            $display("FAIL req_abort_same: pend=%b abrtd=%b want 0000/1000", pending, txabrtd);
        end
        step();
        checks++;
        if (txabrtd !== 4'b0000 || sched_state !== S_IDLE) begin
            errors++;
            $display("FAIL req_abort_pulse: abrtd=%b st=%0d want 0000/0", txabrtd, sched_state);
        end
    endtask

    task automatic test_init_mid_tx();
        int cyc;
        pulse_req(4'b0100);
        wait_req(cyc);
        do_trans();
        initreqr = 1'b1;
        step();
        initreqr = 1'b0;
        checks++;
        if (pending !== 4'b0000 || traregbit !== 1'b0 || txdone !== 4'b0000 || sched_state !== S_IDLE) begin
            errors++;
            $display("FAIL init_clear: pend=%b trareg=%b done=%b st=%0d want 0000/0/0000/0",
                     pending, traregbit, txdone, sched_state);
        end
        do_succ();
        step();
        checks++;
        if (txdone !== 4'b0000 || sched_state !== S_IDLE || traregbit !== 1'b0) begin
            errors++;
            $display("FAIL init_ignore_succ: done=%b st=%0d trareg=%b want 0000/0/0",
                     txdone, sched_state, traregbit);
        end
    endtask

    initial begin
        reset = 1'b1; initreqr = 1'b0;
        txreq = '0; txabort = '0; mbid = '0; mbext = '0;
        trans = 1'b0; sucftranc = 1'b0; arblost = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_retry();
        test_abort();
        test_nonsel_abort();
        test_equal_keys();
        test_init_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
